// File: rtl/irq_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irq_decode_sequencer
// Purpose  : Registered opcode decoder and control sequencer for the
//            accumulator core. It adds skip squashing, a wfi sleep state,
//            and prioritised, non-nesting interrupt entry and exit.
// Options  : IRQ_DECODE_MASK_EN adds a loadable interrupt mask register.
// Revision : 1.0  initial release
// ============================================================================
module irq_decode_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int IRQ_N    = 4,
  parameter int VEC_W    = 2
) (
  input  logic                mem_clock,
  input  logic                reset_bar,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                skip_cond,
  input  logic [IRQ_N-1:0]    irq,
`ifdef IRQ_DECODE_MASK_EN
  input  logic                mask_we,
  input  logic [IRQ_N-1:0]    mask_wdata,
`endif
  output logic [1:0]          pc_mux,
  output logic [1:0]          w_mux,
  output logic                mem_write,
  output logic [3:0]          alu_op,
  output logic                stall,
  output logic [IRQ_N-1:0]    irq_ack,
  output logic [VEC_W-1:0]    irq_vec,
  output logic                int_active
);

  localparam int MAJ_W = OPCODE_W - 1;

  localparam logic [1:0] c_PC_ADD  = 2'd0;
  localparam logic [1:0] c_PC_WREG = 2'd1;
  localparam logic [1:0] c_PC_LIT  = 2'd2;
  localparam logic [1:0] c_PC_SAVE = 2'd3;

  localparam logic [1:0] c_W_ALU  = 2'd0;
  localparam logic [1:0] c_W_MEM  = 2'd1;
  localparam logic [1:0] c_W_LIT  = 2'd2;
  localparam logic [1:0] c_W_WREG = 2'd3;

  localparam logic [3:0] c_ALU_ROTL  = 4'h0;
  localparam logic [3:0] c_ALU_ROTR  = 4'h1;
  localparam logic [3:0] c_ALU_ADD   = 4'h2;
  localparam logic [3:0] c_ALU_SUB   = 4'h3;
  localparam logic [3:0] c_ALU_AND   = 4'h4;
  localparam logic [3:0] c_ALU_OR    = 4'h5;
  localparam logic [3:0] c_ALU_XOR   = 4'h6;
  localparam logic [3:0] c_ALU_ZEROT = 4'h7;
  localparam logic [3:0] c_ALU_PCZ   = 4'h8;
  localparam logic [3:0] c_ALU_PCZB  = 4'h9;
  localparam logic [3:0] c_ALU_NOP   = 4'hA;

  typedef enum logic [0:0] {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  state_t              r_state, w_nxt_state;
  logic [1:0]          r_pc_mux, w_nxt_pc;
  logic [1:0]          r_w_mux, w_nxt_w;
  logic                r_mem_write, w_nxt_mw;
  logic [3:0]          r_alu_op, w_nxt_alu;
  logic                r_stall, w_nxt_stall;
  logic [IRQ_N-1:0]    r_irq_ack, w_nxt_ack;
  logic [VEC_W-1:0]    r_irq_vec, w_nxt_vec;
  logic                r_int_active, w_nxt_int;
  logic                r_skip_pend, w_nxt_skip;

  logic [IRQ_N-1:0]    w_irq_en;
  logic                w_irq_any;
  logic [IRQ_N-1:0]    w_irq_low;
  logic [VEC_W-1:0]    w_irq_idx;
  logic                w_skip_now;
  logic                w_arith;
  logic                w_dest;
  logic [MAJ_W-1:0]    w_major;

`ifdef IRQ_DECODE_MASK_EN
  logic [IRQ_N-1:0]    r_irq_mask;

  // Interrupt mask register, loaded by software, all lines enabled out of reset
  always_ff @(posedge mem_clock or negedge reset_bar) begin
    if (!reset_bar)   r_irq_mask <= '1;
    else if (mask_we) r_irq_mask <= mask_wdata;
  end

  assign w_irq_en = irq & r_irq_mask;
`else
  assign w_irq_en = irq;
`endif

  assign w_irq_any = |w_irq_en;
  // Isolate the lowest set bit: index 0 has the highest priority
  assign w_irq_low = w_irq_en & (~w_irq_en + IRQ_N'(1));
  assign w_major   = opcode[OPCODE_W-1:1];
  assign w_dest    = opcode[0];

  // A sms/smc currently on the outputs plus a true zero-test squashes the
  // next valid instruction, whether it arrives now or after idle cycles
  assign w_skip_now = r_skip_pend |
                      (((r_alu_op == c_ALU_PCZ) || (r_alu_op == c_ALU_PCZB)) && skip_cond);

  // Priority encode the enabled requests into a vector index
  always_comb begin
    w_irq_idx = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (w_irq_en[i]) w_irq_idx = VEC_W'(i);
    end
  end

  // Next-state and next-output logic; defaults are the NOP outputs
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = c_PC_ADD;
    w_nxt_w     = c_W_WREG;
    w_nxt_mw    = 1'b0;
    w_nxt_alu   = c_ALU_NOP;
    w_nxt_stall = 1'b0;
    w_nxt_ack   = '0;
    w_nxt_vec   = r_irq_vec;
    w_nxt_int   = r_int_active;
    w_nxt_skip  = r_skip_pend;
    w_arith     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (instr_valid && !r_int_active && w_irq_any) begin
          // Interrupt entry wins over decode; the opcode is re-fetched after return
          w_nxt_pc   = c_PC_SAVE;
          w_nxt_ack  = w_irq_low;
          w_nxt_vec  = w_irq_idx;
          w_nxt_int  = 1'b1;
          w_nxt_skip = 1'b0;
        end else if (instr_valid && w_skip_now) begin
          w_nxt_skip = 1'b0;
        end else if (instr_valid) begin
          w_nxt_skip = 1'b0;
          case (w_major)
            MAJ_W'(0): begin
              w_nxt_alu = c_ALU_ZEROT;
              w_nxt_mw  = w_dest;
              w_nxt_w   = w_dest ? c_W_WREG : c_W_MEM;
            end
            MAJ_W'(1): w_nxt_mw = 1'b1;
            MAJ_W'(2): w_nxt_w  = c_W_LIT;
            MAJ_W'(3): begin w_nxt_alu = c_ALU_ROTL; w_arith = 1'b1; end
            MAJ_W'(4): begin w_nxt_alu = c_ALU_ROTR; w_arith = 1'b1; end
            MAJ_W'(5): begin w_nxt_alu = c_ALU_AND;  w_arith = 1'b1; end
            MAJ_W'(6): begin w_nxt_alu = c_ALU_OR;   w_arith = 1'b1; end
            MAJ_W'(7): begin w_nxt_alu = c_ALU_XOR;  w_arith = 1'b1; end
            MAJ_W'(8): begin w_nxt_alu = c_ALU_ADD;  w_arith = 1'b1; end
            MAJ_W'(9): begin w_nxt_alu = c_ALU_SUB;  w_arith = 1'b1; end
            MAJ_W'(10): w_nxt_alu = c_ALU_PCZ;
            MAJ_W'(11): w_nxt_alu = c_ALU_PCZB;
            MAJ_W'(12): w_nxt_pc  = c_PC_LIT;
            MAJ_W'(13): w_nxt_pc  = c_PC_WREG;
            MAJ_W'(14): begin
              w_nxt_pc    = c_PC_SAVE;
              w_nxt_stall = 1'b1;
              w_nxt_state = S_WAIT;
            end
            MAJ_W'(15): begin
              if (r_int_active) begin
                w_nxt_pc  = c_PC_SAVE;
                w_nxt_int = 1'b0;
              end
            end
            default: ;
          endcase
          if (w_arith) begin
            w_nxt_mw = w_dest;
            w_nxt_w  = w_dest ? c_W_WREG : c_W_ALU;
          end
        end else begin
          w_nxt_skip = w_skip_now;
        end
      end
      S_WAIT: begin
        // Asleep until an enabled request; inside an ISR nothing can wake it
        w_nxt_stall = 1'b1;
        if (!r_int_active && w_irq_any) begin
          w_nxt_stall = 1'b0;
          w_nxt_state = S_RUN;
          w_nxt_pc    = c_PC_SAVE;
          w_nxt_ack   = w_irq_low;
          w_nxt_vec   = w_irq_idx;
          w_nxt_int   = 1'b1;
          w_nxt_skip  = 1'b0;
        end
      end
      default: w_nxt_state = S_RUN;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge mem_clock or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state      <= S_RUN;
      r_pc_mux     <= c_PC_ADD;
      r_w_mux      <= c_W_WREG;
      r_mem_write  <= 1'b0;
      r_alu_op     <= c_ALU_NOP;
      r_stall      <= 1'b0;
      r_irq_ack    <= '0;
      r_irq_vec    <= '0;
      r_int_active <= 1'b0;
      r_skip_pend  <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_pc_mux     <= w_nxt_pc;
      r_w_mux      <= w_nxt_w;
      r_mem_write  <= w_nxt_mw;
      r_alu_op     <= w_nxt_alu;
      r_stall      <= w_nxt_stall;
      r_irq_ack    <= w_nxt_ack;
      r_irq_vec    <= w_nxt_vec;
      r_int_active <= w_nxt_int;
      r_skip_pend  <= w_nxt_skip;
    end
  end

  assign pc_mux     = r_pc_mux;
  assign w_mux      = r_w_mux;
  assign mem_write  = r_mem_write;
  assign alu_op     = r_alu_op;
  assign stall      = r_stall;
  assign irq_ack    = r_irq_ack;
  assign irq_vec    = r_irq_vec;
  assign int_active = r_int_active;

endmodule
`default_nettype wire

// File: tb/tb_irq_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_decode_sequencer
// Purpose  : Self-checking bench for irq_decode_sequencer: a decode vector
//            table plus directed skip, wfi, interrupt and reset sequences.
// Options  : IRQ_DECODE_MASK_EN enables the mask sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_decode_sequencer;

  logic       mem_clock;
  logic       reset_bar;
  logic [4:0] opcode;
  logic       instr_valid;
  logic       skip_cond;
  logic [3:0] irq;
  logic [1:0] pc_mux;
  logic [1:0] w_mux;
  logic       mem_write;
  logic [3:0] alu_op;
  logic       stall;
  logic [3:0] irq_ack;
  logic [1:0] irq_vec;
  logic       int_active;
`ifdef IRQ_DECODE_MASK_EN
  logic       mask_we;
  logic [3:0] mask_wdata;
`endif

  int n_cmp;
  int n_bad;

  irq_decode_sequencer #(.OPCODE_W(5), .IRQ_N(4), .VEC_W(2)) dut (
    .mem_clock  (mem_clock),
    .reset_bar  (reset_bar),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .skip_cond  (skip_cond),
    .irq        (irq),
`ifdef IRQ_DECODE_MASK_EN
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
`endif
    .pc_mux     (pc_mux),
    .w_mux      (w_mux),
    .mem_write  (mem_write),
    .alu_op     (alu_op),
    .stall      (stall),
    .irq_ack    (irq_ack),
    .irq_vec    (irq_vec),
    .int_active (int_active)
  );

  initial mem_clock = 1'b0;
  always #5 mem_clock = ~mem_clock;

  typedef struct {
    logic [4:0] op;
    logic       vld;
    logic [9:0] exp;   // {pc_mux, w_mux, mem_write, alu_op, stall}
  } vec_t;

  function automatic logic [9:0] mk(input logic [1:0] pc, input logic [1:0] w,
                                    input logic mw, input logic [3:0] alu, input logic st);
    return {pc, w, mw, alu, st};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic [4:0] op, input logic v, input logic sc, input logic [3:0] iq);
    opcode      = op;
    instr_valid = v;
    skip_cond   = sc;
    irq         = iq;
    @(posedge mem_clock);
    #1;
  endtask

  function automatic logic [9:0] ctl();
    return {pc_mux, w_mux, mem_write, alu_op, stall};
  endfunction

  vec_t tbl[21];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    opcode = '0; instr_valid = 0; skip_cond = 0; irq = '0;
`ifdef IRQ_DECODE_MASK_EN
    mask_we = 0; mask_wdata = '0;
`endif
    tbl[0]  = '{5'h10, 1'b1, mk(2'd0, 2'd0, 1'b0, 4'h2, 1'b0)};
    tbl[1]  = '{5'h11, 1'b1, mk(2'd0, 2'd3, 1'b1, 4'h2, 1'b0)};
    tbl[2]  = '{5'h00, 1'b1, mk(2'd0, 2'd1, 1'b0, 4'h7, 1'b0)};
    tbl[3]  = '{5'h01, 1'b1, mk(2'd0, 2'd3, 1'b1, 4'h7, 1'b0)};
    tbl[4]  = '{5'h02, 1'b1, mk(2'd0, 2'd3, 1'b1, 4'hA, 1'b0)};
    tbl[5]  = '{5'h04, 1'b1, mk(2'd0, 2'd2, 1'b0, 4'hA, 1'b0)};
    tbl[6]  = '{5'h06, 1'b1, mk(2'd0, 2'd0, 1'b0, 4'h0, 1'b0)};
    tbl[7]  = '{5'h07, 1'b1, mk(2'd0, 2'd3, 1'b1, 4'h0, 1'b0)};
    tbl[8]  = '{5'h08, 1'b1, mk(2'd0, 2'd0, 1'b0, 4'h1, 1'b0)};
    tbl[9]  = '{5'h0A, 1'b1, mk(2'd0, 2'd0, 1'b0, 4'h4, 1'b0)};
    tbl[10] = '{5'h0C, 1'b1, mk(2'd0, 2'd0, 1'b0, 4'h5, 1'b0)};
    tbl[11] = '{5'h0E, 1'b1, mk(2'd0, 2'd0, 1'b0, 4'h6, 1'b0)};
    tbl[12] = '{5'h12, 1'b1, mk(2'd0, 2'd0, 1'b0, 4'h3, 1'b0)};
    tbl[13] = '{5'h13, 1'b1, mk(2'd0, 2'd3, 1'b1, 4'h3, 1'b0)};
    tbl[14] = '{5'h14, 1'b1, mk(2'd0, 2'd3, 1'b0, 4'h8, 1'b0)};
    tbl[15] = '{5'h16, 1'b1, mk(2'd0, 2'd3, 1'b0, 4'h9, 1'b0)};
    tbl[16] = '{5'h18, 1'b1, mk(2'd2, 2'd3, 1'b0, 4'hA, 1'b0)};
    tbl[17] = '{5'h1A, 1'b1, mk(2'd1, 2'd3, 1'b0, 4'hA, 1'b0)};
    tbl[18] = '{5'h1E, 1'b1, mk(2'd0, 2'd3, 1'b0, 4'hA, 1'b0)};
    tbl[19] = '{5'h10, 1'b0, mk(2'd0, 2'd3, 1'b0, 4'hA, 1'b0)};
    tbl[20] = '{5'h0F, 1'b1, mk(2'd0, 2'd3, 1'b1, 4'h6, 1'b0)};

    // Reset values
    reset_bar = 1'b0;
    repeat (2) @(posedge mem_clock);
    #1;
    check("reset_ctl", 32'(ctl()), 32'(mk(2'd0, 2'd3, 1'b0, 4'hA, 1'b0)));
    check("reset_irq", {26'd0, irq_ack, irq_vec}, 32'd0);
    check("reset_int", 32'(int_active), 32'd0);
    reset_bar = 1'b1;

    // Decode table
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].op, tbl[i].vld, 1'b0, 4'h0);
      check($sformatf("tbl[%0d]", i), 32'(ctl()), 32'(tbl[i].exp));
    end

    // Skip taken on the following instruction
    cyc(5'h14, 1, 0, 4'h0);
    check("sms_alu", 32'(alu_op), 32'h8);
    cyc(5'h02, 1, 1, 4'h0);
    check("skip_taken", 32'(ctl()), 32'(mk(2'd0, 2'd3, 1'b0, 4'hA, 1'b0)));
    cyc(5'h02, 1, 0, 4'h0);
    check("after_skip", 32'(mem_write), 32'd1);
    // Skip not taken
    cyc(5'h14, 1, 0, 4'h0);
    cyc(5'h02, 1, 0, 4'h0);
    check("skip_not_taken", 32'(mem_write), 32'd1);
    // Skip pending held across idle cycles
    cyc(5'h16, 1, 0, 4'h0);
    cyc(5'h02, 0, 1, 4'h0);
    cyc(5'h02, 0, 0, 4'h0);
    cyc(5'h02, 1, 0, 4'h0);
    check("skip_held", 32'(mem_write), 32'd0);
    cyc(5'h02, 1, 0, 4'h0);
    check("skip_cleared", 32'(mem_write), 32'd1);

    // wfi and wake-up
    cyc(5'h1C, 1, 0, 4'h0);
    check("wfi_ctl", 32'(ctl()), 32'(mk(2'd3, 2'd3, 1'b0, 4'hA, 1'b1)));
    for (int i = 0; i < 5; i++) begin
      cyc(5'h10, (i % 2) == 0, 0, 4'h0);
      check($sformatf("wait[%0d]", i), 32'(ctl()), 32'(mk(2'd0, 2'd3, 1'b0, 4'hA, 1'b1)));
    end
    cyc(5'h00, 0, 0, 4'b0110);
    check("wake_ack", 32'(irq_ack), 32'b0010);
    check("wake_vec", 32'(irq_vec), 32'd1);
    check("wake_int", 32'(int_active), 32'd1);
    check("wake_ctl", 32'(ctl()), 32'(mk(2'd3, 2'd3, 1'b0, 4'hA, 1'b0)));
    cyc(5'h10, 1, 0, 4'b0110);
    check("no_nest_ack", 32'(irq_ack), 32'd0);
    check("isr_decode", 32'(ctl()), 32'(mk(2'd0, 2'd0, 1'b0, 4'h2, 1'b0)));
    check("vec_held", 32'(irq_vec), 32'd1);
    cyc(5'h10, 1, 0, 4'b0001);
    check("no_nest_ack2", 32'(irq_ack), 32'd0);
    cyc(5'h1E, 1, 0, 4'b0001);
    check("rfi_pc", 32'(pc_mux), 32'd3);
    check("rfi_int", 32'(int_active), 32'd0);
    check("rfi_ack", 32'(irq_ack), 32'd0);
    cyc(5'h10, 1, 0, 4'b0001);
    check("reentry_ack", 32'(irq_ack), 32'b0001);
    check("reentry_vec", 32'(irq_vec), 32'd0);
    check("reentry_int", 32'(int_active), 32'd1);
    check("reentry_ctl", 32'(ctl()), 32'(mk(2'd3, 2'd3, 1'b0, 4'hA, 1'b0)));
    cyc(5'h10, 0, 0, 4'b0001);
    check("ack_one_cycle", 32'(irq_ack), 32'd0);

    // wfi inside the ISR cannot be woken; async reset clears everything
    cyc(5'h1C, 1, 0, 4'b0001);
    cyc(5'h00, 0, 0, 4'b0001);
    cyc(5'h00, 1, 0, 4'b0001);
    check("isr_wait_stall", 32'(stall), 32'd1);
    check("isr_wait_ack", 32'(irq_ack), 32'd0);
    #2;
    reset_bar = 1'b0;
    #1;
    check("async_ctl", 32'(ctl()), 32'(mk(2'd0, 2'd3, 1'b0, 4'hA, 1'b0)));
    check("async_irq", {26'd0, irq_ack, irq_vec}, 32'd0);
    check("async_int", 32'(int_active), 32'd0);
    cyc(5'h00, 0, 0, 4'h0);
    reset_bar = 1'b1;
    cyc(5'h10, 1, 0, 4'h0);
    check("post_reset", 32'(ctl()), 32'(mk(2'd0, 2'd0, 1'b0, 4'h2, 1'b0)));

`ifdef IRQ_DECODE_MASK_EN
    mask_we = 1'b1;
    mask_wdata = 4'b1110;
    cyc(5'h00, 0, 0, 4'h0);
    mask_we = 1'b0;
    cyc(5'h10, 1, 0, 4'b0001);
    check("mask_block", 32'(irq_ack), 32'd0);
    check("mask_decode", 32'(alu_op), 32'h2);
    cyc(5'h10, 1, 0, 4'b0101);
    check("mask_ack", 32'(irq_ack), 32'b0100);
    check("mask_vec", 32'(irq_vec), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
